instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the RV32I core: steps each instruction through fetch, decode, execute, memory and write-back using the decoded control bits. It drives the enable strobes for the IR, PC and register file, and runs the req/ready handshakes to instruction and data memory. It sits between the control unit's outputs and the datapath register/memory enables.

## Interface
- `OPCODE_LENGTH`, 7, opcode width.
- `TIMEOUT_CYCLES`, 16, maximum memory wait cycles before fault. Used only with `MEM_TIMEOUT_EN`; legal range 2..255.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: permission to start the next instruction.
- `Opcode` in OPCODE_LENGTH: opcode of the current IR.
- `regWrite`, `MemRead`, `MemWrite`, `BranchSig`, `Con_Jalr` in 1 each: decoded control bits for the current IR.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a write.
- `ir_we` out 1: IR load strobe.
- `pc_we` out 1: PC update strobe.
- `reg_we` out 1: register file write strobe.
- `retired` out 1: one-cycle pulse per completed instruction.
- `state` out 3: current state encoding.
- `illegal` out 1: sticky illegal-opcode flag.
- `timeout_err` out 1: sticky memory-timeout flag.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable; if entered, go to HALT.
- IDLE: all strobes 0. Go to FETCH when `run`=1.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready`=1: `ir_we`=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE:
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 0001111.
  - Legal opcode: go to EXEC.
  - Any other opcode: go to HALT and set `illegal`.
- EXEC, evaluated in this order:
  - `MemRead` or `MemWrite` = 1: go to MEM.
  - Else `regWrite`=1 (R-type, I-type, JALR): go to WB.
  - Else (branch, fence): `pc_we`=1 and `retired`=1 this cycle, then go to the boundary target.
- MEM:
  - `dmem_req`=1 and `dmem_we`=`MemWrite` for every cycle in this state.
  - On `dmem_ready`=1 with `MemRead`=1: go to WB.
  - On `dmem_ready`=1 with store: `pc_we`=1 and `retired`=1 this cycle, then go to the boundary target.
- WB: `reg_we`=1, `pc_we`=1 and `retired`=1 for exactly one cycle, then go to the boundary target.
- Boundary target: FETCH if `run`=1, otherwise IDLE. `run` is sampled only at instruction boundaries; deasserting it mid-instruction does not abort the instruction.
- HALT: all strobes 0, `state`=6, stay here until `reset`.
- Control inputs are level-sampled. They must stay stable from the cycle after `ir_we` until the instruction retires.
- `imem_ready` outside FETCH and `dmem_ready` outside MEM are ignored.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE. All outputs 0: `imem_req`, `dmem_req`, `dmem_we`, `ir_we`, `pc_we`, `reg_we`, `retired`, `illegal`, `timeout_err`. Wait counter = 0.
- Reset mid-handshake drops `imem_req`/`dmem_req` in the same cycle.
- Strobes are decoded combinationally from the state register plus the ready inputs. The state register updates on the `clk` rising edge.
- Cycles from entering FETCH to `retired`, with ready returned in the first request cycle:
  - Branch/fence: 3.
  - Store: 4.
  - R-type, I-type, JALR: 4.
  - Load: 5.
- Each wait cycle on `imem_ready` or `dmem_ready` adds 1 cycle.
- With `run` held at 1, back-to-back instructions have no idle gap: FETCH follows the retire cycle directly.
- `pc_we` and `retired` are always coincident. `reg_we` asserts only in WB.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - If `TIMEOUT_CYCLES` consecutive cycles pass without ready: go to HALT, set `timeout_err`, drop the request.
  - If ready arrives in the same cycle the count reaches `TIMEOUT_CYCLES`, ready wins and no fault is raised.
- `MEM_TIMEOUT_EN` undefined: no counter; waits are unbounded; `timeout_err` is tied to 0.

## Test plan
- Reset released, `run`=1, ADD (0110011, `regWrite`=1), both readys tied high → `ir_we` at cycle 0, `reg_we`/`pc_we`/`retired` at cycle 3, FETCH again at cycle 4.
- LW (0000011, `MemRead`=1), `dmem_ready` delayed 3 cycles → `dmem_req`=1 for 4 cycles, `dmem_we`=0, `reg_we` in the cycle after ready, total 8 cycles.
- SW (0100011, `MemWrite`=1) then BEQ (1100011) → SW: `dmem_we`=1, `pc_we` in the ready cycle, no `reg_we`. BEQ: `pc_we` at cycle 2, no `reg_we`.
- Opcode 1111111 → HALT at cycle 2, `illegal`=1, no strobes afterward; pulse `reset` → IDLE with `illegal`=0.
- `run` dropped during MEM of a load → instruction completes through WB, then IDLE with no `imem_req`; `run`=1 → FETCH next cycle.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `imem_ready` held at 0 → HALT after 16 request cycles, `timeout_err`=1. Repeat with ready at count 16 → no fault. Assert `reset` mid-FETCH → `imem_req` drops the same cycle.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with IR/PC/regfile strobes and memory handshakes.
// Optional MEM_TIMEOUT_EN adds a bounded memory wait that faults into HALT with a sticky timeout_err.
module instr_sequencer #(
  parameter int OPCODE_LENGTH  = 7,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [OPCODE_LENGTH-1:0] Opcode,
  input  logic                     regWrite,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic                     BranchSig,
  input  logic                     Con_Jalr,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  output logic                     imem_req,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic                     reg_we,
  output logic                     retired,
  output logic [2:0]               state,
  output logic                     illegal,
  output logic                     timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  state_t cur, nxt, boundary;
  logic   op_legal;
  logic   set_illegal;
  logic   expired;

  // Branch/JALR distinctions are resolved by the control unit before they reach us.
  logic unused_ctrl;
  assign unused_ctrl = ^{BranchSig, Con_Jalr};

  assign state    = cur;
  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    case (Opcode)
      OPCODE_LENGTH'(7'b0110011),
      OPCODE_LENGTH'(7'b0010011),
      OPCODE_LENGTH'(7'b0000011),
      OPCODE_LENGTH'(7'b0100011),
      OPCODE_LENGTH'(7'b1100011),
      OPCODE_LENGTH'(7'b1100111),
      OPCODE_LENGTH'(7'b0001111): op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       mem_wait;

  assign mem_wait = ((cur == S_FETCH) && !imem_ready) || ((cur == S_MEM) && !dmem_ready);
  // Fault in the cycle the count would reach the limit; a ready in that cycle wins.
  assign expired  = mem_wait && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if (nxt != cur)    wait_cnt <= 8'd0;
      else if (mem_wait) wait_cnt <= wait_cnt + 8'd1;
      if (expired)       timeout_err <= 1'b1;
    end
  end
`else
  logic unused_param;
  assign unused_param = ^8'(TIMEOUT_CYCLES);
  assign expired      = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    retired     = 1'b0;
    set_illegal = 1'b0;
    case (cur)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (expired) begin
          nxt = S_HALT;
        end
      end
      S_DECODE: begin
        nxt         = op_legal ? S_EXEC : S_HALT;
        set_illegal = !op_legal;
      end
      S_EXEC: begin
        if (MemRead || MemWrite) nxt = S_MEM;
        else if (regWrite)       nxt = S_WB;
        else begin
          pc_we   = 1'b1;
          retired = 1'b1;
          nxt     = boundary;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite;
        if (dmem_ready) begin
          if (MemRead) nxt = S_WB;
          else begin
            pc_we   = 1'b1;
            retired = 1'b1;
            nxt     = boundary;
          end
        end else if (expired) begin
          nxt = S_HALT;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retired = 1'b1;
        nxt     = boundary;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver queues per-instruction expectations, a negedge monitor checks retires.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic       regWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, BranchSig = 1'b0, Con_Jalr = 1'b0;
  logic       imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retired, illegal, timeout_err;
  logic [2:0] state;

  instr_sequencer #(.OPCODE_LENGTH(7), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .run(run), .Opcode(Opcode),
    .regWrite(regWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .BranchSig(BranchSig), .Con_Jalr(Con_Jalr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .retired(retired),
    .state(state), .illegal(illegal), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    lat;
    int    reg_w;
    int    dreq;
    int    dwe;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   imem_delay = 0;
  int   dmem_delay = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic give_up(input string name);
    check(name, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  // Memory responders: ready appears after the configured number of request cycles.
  initial begin
    int iw = 0;
    int dw = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req === 1'b1) begin imem_ready = (iw >= imem_delay); iw++; end
      else begin imem_ready = 1'b0; iw = 0; end
      if (dmem_req === 1'b1) begin dmem_ready = (dw >= dmem_delay); dw++; end
      else begin dmem_ready = 1'b0; dw = 0; end
    end
  end

  // Monitor: per instruction, latency from FETCH entry, memory request/write cycles, strobes at retire.
  initial begin
    bit   act = 0;
    int   cyc = 0, dreq = 0, dwe = 0, irw = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin act = 0; continue; end
      if (!act && imem_req) begin act = 1; cyc = 0; dreq = 0; dwe = 0; irw = 0; end
      if (pc_we || retired) check("pc_we_vs_retired", pc_we, retired);
      if (reg_we) check("reg_we_only_in_wb", state, 5);
      if (act) begin
        dreq += int'(dmem_req);
        dwe  += int'(dmem_we);
        irw  += int'(ir_we);
        if (retired) begin
          if (q.size() == 0) check("unexpected_retire", 1, 0);
          else begin
            e = q.pop_front();
            check({e.name, "_latency"}, cyc, e.lat);
            check({e.name, "_reg_we"}, reg_we, e.reg_w);
            check({e.name, "_dmem_req_cycles"}, dreq, e.dreq);
            check({e.name, "_dmem_we_cycles"}, dwe, e.dwe);
            check({e.name, "_ir_we_count"}, irw, 1);
          end
          act = 0;
        end else cyc++;
      end
    end
  end

  // stop: 0 keep run high, 1 drop run during FETCH, 2 drop run once MEM is reached.
  task automatic issue(input string name, input logic [6:0] op, input logic rw, input logic mr,
                       input logic mw, input int idly, input int ddly, input int lat, input int stop);
    int polls = 0;
    exp_t e;
    imem_delay = idly;
    dmem_delay = ddly;
    run = 1'b1;
    do begin
      @(posedge clk); #2; polls++;
      if (polls > 20) give_up({name, "_fetch_wait"});
    end while (imem_req !== 1'b1);
    check({name, "_fetch_gap"}, polls, 1);
    Opcode = op; regWrite = rw; MemRead = mr; MemWrite = mw;
    BranchSig = (op == 7'b1100011);
    Con_Jalr  = (op == 7'b1100111);
    e.name  = name;
    e.lat   = lat;
    e.reg_w = int'(rw);
    e.dreq  = (mr || mw) ? ddly + 1 : 0;
    e.dwe   = mw ? ddly + 1 : 0;
    q.push_back(e);
    if (stop == 1) run = 1'b0;
    polls = 0;
    while (retired !== 1'b1) begin
      @(posedge clk); #2; polls++;
      if (stop == 2 && dmem_req === 1'b1) run = 1'b0;
      if (polls > 60) give_up({name, "_retire_wait"});
    end
  endtask

  initial begin
    #200000;
    give_up("global_watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", state, 0);
    check("reset_outputs", {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retired, illegal, timeout_err}, 0);
    reset = 1'b0;
    @(posedge clk); #2;
    check("idle_no_fetch", imem_req, 0);

    // Back-to-back program with run held high.
    issue("add",   7'b0110011, 1, 0, 0, 0, 0, 3, 0);
    issue("lw",    7'b0000011, 1, 1, 0, 0, 3, 7, 0);
    issue("sw",    7'b0100011, 0, 0, 1, 0, 0, 3, 0);
    issue("beq",   7'b1100011, 0, 0, 0, 0, 0, 2, 0);
    issue("addi",  7'b0010011, 1, 0, 0, 2, 0, 5, 0);
    issue("jalr",  7'b1100111, 1, 0, 0, 0, 0, 3, 0);
    issue("fence", 7'b0001111, 0, 0, 0, 0, 0, 2, 0);
    issue("lw_drop", 7'b0000011, 1, 1, 0, 0, 1, 5, 2);

    @(posedge clk); #2;
    check("after_drop_state", state, 0);
    check("after_drop_imem_req", imem_req, 0);

    // Illegal opcode from IDLE.
    imem_delay = 0;
    run = 1'b1;
    @(posedge clk); #2;
    check("illegal_fetch_state", state, 1);
    Opcode = 7'b1111111; regWrite = 0; MemRead = 0; MemWrite = 0; BranchSig = 0; Con_Jalr = 0;
    run = 1'b0;
    @(posedge clk); #2;
    check("illegal_decode_state", state, 2);
    @(posedge clk); #2;
    check("illegal_halt_state", state, 6);
    check("illegal_flag", illegal, 1);
    run = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("halt_no_strobes", {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retired}, 0);
    end
    check("halt_stays", state, 6);
    run = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_from_halt_state", state, 0);
    check("reset_clears_illegal", illegal, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Reset in the middle of a fetch handshake.
    imem_delay = 10;
    run = 1'b1;
    @(posedge clk); #2;
    check("midfetch_req_before", imem_req, 1);
    run = 1'b0;
    reset = 1'b1;
    #1;
    check("midfetch_req_dropped", imem_req, 0);
    check("midfetch_state", state, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    imem_delay = 0;

`ifdef MEM_TIMEOUT_EN
    imem_delay = 100;
    run = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      run = 1'b0;
      if (state == 3'd6) break;
      if (imem_req === 1'b1) n++;
    end
    check("timeout_req_cycles", n, 16);
    check("timeout_state", state, 6);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_req_dropped", imem_req, 0);
    reset = 1'b1;
    #1;
    check("reset_clears_timeout", timeout_err, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    issue("add_ready_at_limit", 7'b0110011, 1, 0, 0, 15, 0, 18, 1);
    @(posedge clk); #2;
    check("limit_no_fault", timeout_err, 0);
    check("limit_idle", state, 0);
`else
    n = 0;
    check("timeout_err_tied_low", timeout_err, n);
`endif

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
